// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch buffer.
//   NOP_INST      : instruction presented while the queue is empty
//   fetch_state_e : request tracker states (IDLE / WAIT / DROP)
//   fetch_entry_t : queue entry {pc, inst}; PC_W fixes the pc field width
package fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    // IDLE: nothing outstanding, WAIT: live request, DROP: stale request
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular queue with push, pop and synchronous flush.
//   clk, rst   : clock, asynchronous active-low reset
//   push       : write push_data at the tail (ignored when full without a pop)
//   pop        : drop the head (ignored when empty)
//   flush      : empty the queue this edge; overrides push and pop
//   head_data  : current head entry (stale contents when empty)
//   count      : number of occupied entries
module fetch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    // A pop frees the head slot, so a push into a full queue is allowed then
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch front end: issues one word fetch at a time, queues the
// returned {pc, inst} pairs for decode and handles redirects from ID.
//   clk, rst                        : clock, asynchronous active-low reset
//   imem_req_valid/addr/ready       : fetch request handshake
//   imem_resp_valid/inst            : returned instruction word
//   redirect_valid/pc               : branch/jump redirect (flushes queue)
//   out_valid/ready/pc/inst         : head of queue towards decode
//   count                           : occupied queue entries
module inst_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned    XLEN     = 32,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    output logic [XLEN-1:0]        imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_resp_valid,
    input  logic [31:0]            imem_resp_inst,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [31:0]            out_inst,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // The queue entry layout comes from the package, so XLEN must match it
    if (XLEN != PC_W) begin : g_xlen_check
        $error("inst_fetch_buffer: XLEN must equal fetch_pkg::PC_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("inst_fetch_buffer: DEPTH must be a power of 2 and >= 2");
    end

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [CNT_W-1:0] fifo_count;
    logic            room, req_fire, push, pop, not_empty;
    fetch_entry_t    push_entry, head_entry;

    // Credit rule: only request when the response is guaranteed a slot
    assign room           = (fifo_count < CNT_W'(DEPTH));
    assign imem_req_valid = rst & (state_q == ST_IDLE) & ~redirect_valid & room;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign not_empty = (fifo_count != '0);
    assign out_valid = not_empty & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign push      = (state_q == ST_WAIT) & imem_resp_valid & ~redirect_valid;

    assign push_entry = '{pc: req_pc_q, inst: imem_resp_inst};

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    assign out_pc   = not_empty ? head_entry.pc   : '0;
    assign out_inst = not_empty ? head_entry.inst : NOP_INST;
    assign count    = fifo_count;

    // Request tracker; a response always retires the outstanding request,
    // even if a redirect arrives in the same cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_fire) state_d = ST_WAIT;
            ST_WAIT: begin
                if (imem_resp_valid)     state_d = ST_IDLE;
                else if (redirect_valid) state_d = ST_DROP;
            end
            ST_DROP: if (imem_resp_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Fetch PC: redirect target (word aligned) or sequential advance
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (req_fire) req_pc_d = fetch_pc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
module tb_inst_fetch_buffer;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic             rst_n;
    logic             imem_req_valid, imem_req_ready;
    logic [XLEN-1:0]  imem_req_addr;
    logic             imem_resp_valid;
    logic [31:0]      imem_resp_inst;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             out_valid, out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [31:0]      out_inst;
    logic [CNT_W-1:0] count;

    // wrap-around instance
    logic             w_rst_n;
    logic             w_req_valid, w_req_ready;
    logic [XLEN-1:0]  w_req_addr;
    logic             w_resp_valid;
    logic [31:0]      w_resp_inst;
    logic             w_redirect_valid;
    logic [XLEN-1:0]  w_redirect_pc;
    logic             w_out_valid, w_out_ready;
    logic [XLEN-1:0]  w_out_pc;
    logic [31:0]      w_out_inst;
    logic [CNT_W-1:0] w_count;

    inst_fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_inst(imem_resp_inst), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .count(count)
    );

    inst_fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .rst(w_rst_n),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
        .imem_req_ready(w_req_ready), .imem_resp_valid(w_resp_valid),
        .imem_resp_inst(w_resp_inst), .redirect_valid(w_redirect_valid),
        .redirect_pc(w_redirect_pc), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_pc(w_out_pc), .out_inst(w_out_inst), .count(w_count)
    );

    // reference model: fetch pointer, one outstanding request, FIFO of entries
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_out;
    bit          m_stale;
    int          cd;
    int          lat_cfg;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          first_req = -1;
    int          first_valid = -1;
    bit          out_pc_armed = 0;
    logic [31:0] first_out_pc = 'x;
    logic [31:0] obs_fire[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fire_at(input int i);
        if (i < obs_fire.size()) return obs_fire[i];
        return 'x;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance model
    task automatic step(input bit rdy, input bit ordy, input bit redir,
                        input logic [31:0] rpc, input bit force_resp);
        bit          mem_resp, exp_rv, exp_ov, fire, popped, pushed;
        logic [31:0] exp_pc, exp_inst;
        ent_t        e;
        mem_resp = 1'b0;
        if (cd > 0) begin
            cd--;
            mem_resp = (cd == 0);
        end
        imem_resp_valid = mem_resp | force_resp;
        imem_resp_inst  = $urandom;
        imem_req_ready  = rdy;
        out_ready       = ordy;
        redirect_valid  = redir;
        redirect_pc     = rpc;
        #2;
        exp_rv   = rst_n && !m_out && !redir && (m_q.size() < int'(DEPTH));
        exp_ov   = !redir && (m_q.size() != 0);
        exp_pc   = (m_q.size() != 0) ? m_q[0].pc   : 32'h0;
        exp_inst = (m_q.size() != 0) ? m_q[0].inst : NOP;
        chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        if (exp_rv) chk("req_addr", 64'(imem_req_addr), 64'(m_pc));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("out_pc", 64'(out_pc), 64'(exp_pc));
        chk("out_inst", 64'(out_inst), 64'(exp_inst));
        chk("count", 64'(count), 64'(m_q.size()));

        if (rst_n && imem_req_valid && rdy) begin
            obs_fire.push_back(imem_req_addr);
            if (first_req < 0) first_req = cyc;
        end
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && out_pc_armed) begin
            first_out_pc = out_pc;
            out_pc_armed = 0;
        end

        if (!rst_n) begin
            m_pc    = 32'h0;
            m_out   = 0;
            m_stale = 0;
            m_q.delete();
            cd      = 0;
        end else begin
            fire   = exp_rv && rdy;
            popped = exp_ov && ordy;
            pushed = m_out && !m_stale && imem_resp_valid && !redir;
            if (popped) void'(m_q.pop_front());
            if (pushed) begin
                e.pc   = m_req_pc;
                e.inst = imem_resp_inst;
                m_q.push_back(e);
            end
            if (m_out && imem_resp_valid) m_out = 0;
            else if (m_out && redir) m_stale = 1;
            if (redir) begin
                m_q.delete();
                m_pc = {rpc[31:2], 2'b00};
            end
            if (fire) begin
                m_out    = 1;
                m_stale  = 0;
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
                cd       = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          found;
        logic [31:0] exp_head;

        rst_n = 0; imem_req_ready = 0; imem_resp_valid = 0; imem_resp_inst = '0;
        redirect_valid = 0; redirect_pc = '0; out_ready = 0;
        w_rst_n = 0; w_req_ready = 0; w_resp_valid = 0; w_resp_inst = '0;
        w_redirect_valid = 0; w_redirect_pc = '0; w_out_ready = 0;
        m_pc = 0; m_req_pc = 0; m_out = 0; m_stale = 0; cd = 0; lat_cfg = 1;

        // reset state of both instances; wrap instance exercised meanwhile
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("w_rst_req_valid", 64'(w_req_valid), 64'(0));
        chk("w_rst_count", 64'(w_count), 64'(0));
        chk("w_rst_out_inst", 64'(w_out_inst), 64'(NOP));
        w_rst_n = 1;
        step(0, 0, 0, 0, 0);
        chk("w_first_addr", 64'(w_req_addr), 64'(WRAP_PC));
        chk("w_first_valid", 64'(w_req_valid), 64'(1));
        w_req_ready = 1;
        step(0, 0, 0, 0, 0);
        w_req_ready = 0;
        chk("w_wait_no_req", 64'(w_req_valid), 64'(0));
        w_resp_valid = 1; w_resp_inst = 32'hAAAA_5555;
        step(0, 0, 0, 0, 0);
        w_resp_valid = 0;
        chk("w_wrap_addr", 64'(w_req_addr), 64'(32'h0));
        chk("w_wrap_valid", 64'(w_req_valid), 64'(1));
        chk("w_head_pc", 64'(w_out_pc), 64'(WRAP_PC));
        chk("w_head_inst", 64'(w_out_inst), 64'(32'hAAAA_5555));
        w_req_ready = 1;
        step(0, 0, 0, 0, 0);
        w_req_ready = 0;
        chk("w_second_wait", 64'(w_req_valid), 64'(0));
        w_rst_n = 0;
        step(0, 0, 0, 0, 0);
        chk("w_midrst_count", 64'(w_count), 64'(0));
        w_rst_n = 1; w_resp_valid = 1; w_resp_inst = 32'hDEAD_BEEF;
        step(0, 0, 0, 0, 0);
        w_resp_valid = 0;
        chk("w_stale_resp_count", 64'(w_count), 64'(0));
        chk("w_refetch_addr", 64'(w_req_addr), 64'(WRAP_PC));
        chk("w_refetch_valid", 64'(w_req_valid), 64'(1));

        // streaming with 1-cycle latency
        rst_n = 1; lat_cfg = 1;
        first_req = -1; first_valid = -1; obs_fire.delete();
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
        chk("first_addr0", 64'(fire_at(0)), 64'(32'h0));
        chk("first_addr1", 64'(fire_at(1)), 64'(32'h4));
        chk("first_addr2", 64'(fire_at(2)), 64'(32'h8));
        chk("first_out_latency", 64'(first_valid - first_req), 64'(2));

        // decode stall: queue fills to DEPTH and requests stop
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
        chk("stall_count", 64'(count), 64'(DEPTH));
        chk("stall_no_req", 64'(imem_req_valid), 64'(0));
        obs_fire.delete();
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
        chk("one_pop_one_req", 64'(obs_fire.size()), 64'(1));

        // redirect while a request is in flight
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
        lat_cfg = 2;
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 32'h100, 0);
        obs_fire.delete(); out_pc_armed = 1;
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
        chk("redir_fetch", 64'(fire_at(0)), 64'(32'h100));
        chk("redir_first_out", 64'(first_out_pc), 64'(32'h100));

        // unaligned redirect target
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 32'h103, 0);
        chk("align_addr", 64'(imem_req_addr), 64'(32'h100));
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);

        // simultaneous push and pop at count=2
        lat_cfg = 1;
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_q.size() == 2 && m_out && cd == 1) begin
                found = 1;
                break;
            end
            step(1, 0, 0, 0, 0);
        end
        chk("pushpop_setup", 64'(found), 64'(1));
        exp_head = (m_q.size() > 1) ? m_q[1].pc : 'x;
        step(0, 1, 0, 0, 0);
        chk("pushpop_count", 64'(count), 64'(2));
        chk("pushpop_head", 64'(out_pc), 64'(exp_head));

        // randomized traffic
        lat_cfg = 0;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0, $urandom, 0);
        end

        // reset while waiting: stale response ignored, refetch from RESET_PC
        lat_cfg = 3;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_out) begin
                found = 1;
                break;
            end
            step(1, 1, 0, 0, 0);
        end
        chk("midrst_setup", 64'(found), 64'(1));
        rst_n = 0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        obs_fire.delete();
        rst_n = 1; lat_cfg = 1;
        step(1, 1, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
        chk("midrst_refetch", 64'(fire_at(0)), 64'(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_buffer.md
INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and address width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; must be a power of 2 and at least 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port imem_req_valid, output, 1 bit, fetch request valid.
REQ-007 SHALL have port imem_req_addr, output, XLEN bits, fetch address, word-aligned.
REQ-008 SHALL have port imem_req_ready, input, 1 bit, memory accepts the request.
REQ-009 SHALL have port imem_resp_valid, input, 1 bit, instruction word returned.
REQ-010 SHALL have port imem_resp_inst, input, 32 bits, returned instruction.
REQ-011 SHALL have port redirect_valid, input, 1 bit, branch/jump redirect from ID.
REQ-012 SHALL have port redirect_pc, input, XLEN bits, redirect target.
REQ-013 SHALL have port out_valid, output, 1 bit, head entry available to ID.
REQ-014 SHALL have port out_ready, input, 1 bit, ID consumes the head (low = decode stall).
REQ-015 SHALL have port out_pc, output, XLEN bits, PC of the head entry.
REQ-016 SHALL have port out_inst, output, 32 bits, instruction of the head entry.
REQ-017 SHALL have port count, output, $clog2(DEPTH)+1 bits, occupied entries.

Function
REQ-018 SHALL keep fetch_pc; a request handshake (imem_req_valid & imem_req_ready) latches req_pc=fetch_pc and sets fetch_pc += 4, modulo 2^XLEN with wrap-around.
REQ-019 SHALL keep at most one request outstanding; FSM states IDLE (none outstanding), WAIT (outstanding, live), DROP (outstanding, stale).
REQ-020 SHALL drive imem_req_valid=1 only in IDLE, with no redirect this cycle, and count+0 < DEPTH (credit rule; never overflows).
REQ-021 SHALL transition IDLE->WAIT on request handshake; WAIT->IDLE on imem_resp_valid; DROP->IDLE on imem_resp_valid.
REQ-022 SHALL, in WAIT, push {req_pc, imem_resp_inst} on imem_resp_valid unless redirect_valid is high the same cycle; responses in IDLE are ignored.
REQ-023 SHALL, in DROP, discard the response without pushing.
REQ-024 SHALL, on redirect_valid, in the same edge: empty the queue, set fetch_pc={redirect_pc[XLEN-1:2],2'b00}, move WAIT->DROP; IDLE and DROP remain unchanged.
REQ-025 SHALL force out_valid=0 in a redirect cycle; any out_ready that cycle does not pop.
REQ-026 SHALL drive out_valid=(count!=0); the pop occurs on out_valid & out_ready.
REQ-027 SHALL, on a simultaneous push and pop, leave count unchanged and preserve FIFO order; with count=1 the pushed entry becomes head next cycle.
REQ-028 SHALL present out_pc=0 and out_inst=32'h0000_0013 (NOP) while empty.
REQ-029 SHALL drive outputs combinationally from registered state only; imem_resp_inst passes to out_inst only through the queue (latency at least 1 cycle after response).

Reset
REQ-030 SHALL, while rst=0: set FSM=IDLE, fetch_pc=RESET_PC, count=0, and pointers=0.
REQ-031 SHALL, while rst=0: drive imem_req_valid=0, out_valid=0, out_pc=0, out_inst=NOP.
REQ-032 SHALL treat reset mid-transaction as abandoning the outstanding request; the first response after release is ignored (IDLE).

Structure
REQ-033 SHALL place the NOP constant, the FSM state enum and the queue entry type {pc, inst} in shared package fetch_pkg.
REQ-034 SHALL implement the queue as sub-module fetch_fifo, parametrised WIDTH/DEPTH, with push, pop, flush and count; full/empty derived from count.

Verification
REQ-035 SHALL cover: reset release, ready=1, 1-cycle response latency -> addresses 0x0, 0x4, 0x8 requested; out_pc follows in order, out_valid first high 2 cycles after the first request.
REQ-036 SHALL cover: out_ready=0, DEPTH=4 -> count saturates at 4, imem_req_valid=0, no 5th request; one pop -> exactly one new request.
REQ-037 SHALL cover: redirect_valid to 0x100 while in WAIT -> queue empties; the in-flight response is dropped; the next request is 0x100, and the first output is pc=0x100.
REQ-038 SHALL cover: redirect_pc=0x103 -> request address 0x100.
REQ-039 SHALL cover: push and pop on the same edge at count=2 -> count stays 2; order intact.
REQ-040 SHALL cover: RESET_PC=0xFFFF_FFFC with XLEN=32 -> the second fetch is 0x0000_0000; rst low in WAIT -> response ignored, refetch from RESET_PC.
